// File: rtl/k423_dmem_rsp.sv
// Data-memory responder: byte-writable word SRAM behind a credit-controlled request port,
// with a fixed-latency token pipeline feeding an in-order first-word-fall-through response FIFO.
module k423_dmem_rsp #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int RSP_LAT     = 1,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_data_req_vld_i,
  output logic                mem_data_req_rdy_o,
  input  logic [ADDR_W-1:0]   mem_data_req_addr_i,
  input  logic                mem_data_req_we_i,
  input  logic [DATA_W-1:0]   mem_data_req_wdata_i,
  input  logic [DATA_W/8-1:0] mem_data_req_wstrb_i,
  output logic                mem_data_rsp_vld_o,
  input  logic                mem_data_rsp_rdy_i,
  output logic [DATA_W-1:0]   mem_data_rsp_rdata_o,
  output logic                mem_data_rsp_err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TOK_W = DATA_W + 1;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
      next_ptr = {PTR_W{1'b0}};
    end else begin
      next_ptr = ptr + PTR_W'(1);
    end
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [TOK_W-1:0]  fifo_q [FIFO_DEPTH];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic             req_rdy_s;
  logic             rsp_vld_s;
  logic             req_fire_s;
  logic             rsp_fire_s;
  logic [IDX_W-1:0] idx_s;
  logic             addr_err_s;
  logic [TOK_W-1:0] rd_tok_s;
  logic             push_vld_s;
  logic [TOK_W-1:0] push_tok_s;
  logic [TOK_W-1:0] head_s;

  assign req_rdy_s  = (cnt_q < CNT_W'(FIFO_DEPTH));
  assign rsp_vld_s  = (occ_q != {CNT_W{1'b0}});
  assign req_fire_s = mem_data_req_vld_i & req_rdy_s;
  assign rsp_fire_s = rsp_vld_s & mem_data_rsp_rdy_i;
  assign idx_s      = mem_data_req_addr_i[2 +: IDX_W];
  assign addr_err_s = |(mem_data_req_addr_i >> (IDX_W + 2));

  // Asynchronous array read: a load observes every store committed at earlier edges.
  assign rd_tok_s = (mem_data_req_we_i || addr_err_s) ? {{DATA_W{1'b0}}, addr_err_s}
                                                       : {mem_q[idx_s], 1'b0};

  // Byte-lane array write on the accept edge; out-of-range stores are dropped.
  always_ff @(posedge clk_i) begin
    if (req_fire_s && mem_data_req_we_i && !addr_err_s) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (mem_data_req_wstrb_i[i]) begin
          mem_q[idx_s][8*i +: 8] <= mem_data_req_wdata_i[8*i +: 8];
        end
      end
    end
  end

  generate
    if (RSP_LAT == 1) begin : g_no_pipe
      assign push_vld_s = req_fire_s;
      assign push_tok_s = rd_tok_s;
    end else begin : g_pipe
      logic [RSP_LAT-2:0]            stg_vld_q, stg_vld_d;
      logic [RSP_LAT-2:0][TOK_W-1:0] stg_tok_q, stg_tok_d;

      // Shift the response token along RSP_LAT-1 delay stages.
      always_comb begin
        stg_vld_d    = stg_vld_q;
        stg_tok_d    = stg_tok_q;
        stg_vld_d[0] = req_fire_s;
        stg_tok_d[0] = rd_tok_s;
        for (int i = 1; i < RSP_LAT - 1; i++) begin
          stg_vld_d[i] = stg_vld_q[i-1];
          stg_tok_d[i] = stg_tok_q[i-1];
        end
      end

      // Pipeline stage registers.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          stg_vld_q <= {(RSP_LAT-1){1'b0}};
          stg_tok_q <= {((RSP_LAT-1)*TOK_W){1'b0}};
        end else begin
          stg_vld_q <= stg_vld_d;
          stg_tok_q <= stg_tok_d;
        end
      end

      assign push_vld_s = stg_vld_q[RSP_LAT-2];
      assign push_tok_s = stg_tok_q[RSP_LAT-2];
    end
  endgenerate

  // FIFO storage; entries are qualified by occupancy so they need no reset.
  always_ff @(posedge clk_i) begin
    if (push_vld_s) begin
      fifo_q[wr_ptr_q] <= push_tok_s;
    end
  end

  // Credit, occupancy and pointer next-state.
  always_comb begin
    cnt_d    = cnt_q;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (req_fire_s && !rsp_fire_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!req_fire_s && rsp_fire_s) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    if (push_vld_s && !rsp_fire_s) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (!push_vld_s && rsp_fire_s) begin
      occ_d = occ_q - CNT_W'(1);
    end else begin
      occ_d = occ_q;
    end
    if (push_vld_s) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rsp_fire_s) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= {CNT_W{1'b0}};
      occ_q    <= {CNT_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
    end else begin
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign head_s               = fifo_q[rd_ptr_q];
  assign mem_data_req_rdy_o   = req_rdy_s;
  assign mem_data_rsp_vld_o   = rsp_vld_s;
  assign mem_data_rsp_rdata_o = rsp_vld_s ? head_s[TOK_W-1:1] : {DATA_W{1'b0}};
  assign mem_data_rsp_err_o   = rsp_vld_s ? head_s[0] : 1'b0;

endmodule

// File: tb/tb_k423_dmem_rsp.sv
// Directed self-checking bench for k423_dmem_rsp (RSP_LAT=1, FIFO_DEPTH=2, DEPTH_WORDS=1024).
module tb_k423_dmem_rsp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  k423_dmem_rsp #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .RSP_LAT(1), .FIFO_DEPTH(2)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .mem_data_req_vld_i   (req_vld),
    .mem_data_req_rdy_o   (req_rdy),
    .mem_data_req_addr_i  (req_addr),
    .mem_data_req_we_i    (req_we),
    .mem_data_req_wdata_i (req_wdata),
    .mem_data_req_wstrb_i (req_wstrb),
    .mem_data_rsp_vld_o   (rsp_vld),
    .mem_data_rsp_rdy_i   (rsp_rdy),
    .mem_data_rsp_rdata_o (rsp_rdata),
    .mem_data_rsp_err_o   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One request with rsp_rdy=1 and an empty FIFO: response must appear right after the accept edge.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wstrb,
                      input logic [31:0] exp_rdata, input logic exp_err);
    req_vld = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    chk({tag, "_rdy"}, req_rdy, 1'b1);
    tick;
    req_vld = 1'b0; req_we = 1'b0;
    chk({tag, "_vld"}, rsp_vld, 1'b1);
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_err"}, rsp_err, exp_err);
    tick;
    chk({tag, "_drain"}, rsp_vld, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req_vld = 1'b0; req_addr = 32'h0; req_we = 1'b0;
    req_wdata = 32'h0; req_wstrb = 4'h0; rsp_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", req_rdy, 1'b1);
    chk("rst_vld", rsp_vld, 1'b0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", rsp_err, 1'b0);
    rst = 1'b0;
    tick;

    xact("st10",  1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    xact("ld10",  1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    xact("st20",  1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
    xact("st20b", 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0);
    xact("ld20",  1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
    xact("st20z", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    xact("ld20z", 1'b0, 32'h22, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
    xact("st00",  1'b1, 32'h0, 32'h12345678, 4'hF, 32'h0, 1'b0);

    // Out-of-range: first address past the array and a high address bit, which would alias words 0 and 4.
    xact("ldErr", 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1);
    xact("stErr", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    xact("ld00",  1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678, 1'b0);
    xact("stHi",  1'b1, 32'h80000010, 32'h0, 4'hF, 32'h0, 1'b1);
    xact("ldHi",  1'b0, 32'h80000010, 32'h0, 4'h0, 32'h0, 1'b1);
    xact("ld10b", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Backpressure: two credits, third request must stall.
    rsp_rdy = 1'b0;
    req_vld = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    chk("bp_rdy0", req_rdy, 1'b1);
    tick;
    req_addr = 32'h20;
    chk("bp_rdy1", req_rdy, 1'b1);
    chk("bp_vld1", rsp_vld, 1'b1);
    tick;
    req_addr = 32'h0;
    chk("bp_full", req_rdy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_hold_rdy", req_rdy, 1'b0);
      chk("bp_hold_vld", rsp_vld, 1'b1);
      chk("bp_hold_data", rsp_rdata, 32'hDEADBEEF);
    end
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    tick;
    chk("bp_rsp2_vld", rsp_vld, 1'b1);
    chk("bp_rsp2_data", rsp_rdata, 32'h11BB33DD);
    chk("bp_rsp2_rdy", req_rdy, 1'b1);
    tick;
    chk("bp_empty", rsp_vld, 1'b0);
    chk("bp_rdy_end", req_rdy, 1'b1);

    // Full rate: preload 16 words, then 16 back-to-back loads.
    for (int i = 0; i < 16; i++) begin
      xact("pre", 1'b1, 32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF, 32'h0, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      req_vld = 1'b1; req_we = 1'b0; req_addr = 32'h100 + 32'(4 * i);
      chk("fr_rdy", req_rdy, 1'b1);
      tick;
      chk("fr_vld", rsp_vld, 1'b1);
      chk("fr_data", rsp_rdata, 32'hC0DE0000 + 32'(i));
    end
    req_vld = 1'b0;
    tick;
    chk("fr_end", rsp_vld, 1'b0);

    // Reset with two loads outstanding.
    rsp_rdy = 1'b0;
    req_vld = 1'b1; req_addr = 32'h10;
    tick;
    req_addr = 32'h20;
    tick;
    req_vld = 1'b0;
    chk("rm_vld_pre", rsp_vld, 1'b1);
    chk("rm_rdy_pre", req_rdy, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rm_vld_rst", rsp_vld, 1'b0);
    chk("rm_rdy_rst", req_rdy, 1'b1);
    chk("rm_rdata_rst", rsp_rdata, 32'h0);
    @(posedge clk);
    tick;
    rst = 1'b0;
    rsp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rm_no_stale", rsp_vld, 1'b0);
    end
    // Both credits must be free again after reset.
    rsp_rdy = 1'b0;
    req_vld = 1'b1; req_addr = 32'h10;
    tick;
    chk("rm_cnt1_rdy", req_rdy, 1'b1);
    tick;
    req_vld = 1'b0;
    chk("rm_cnt2_rdy", req_rdy, 1'b0);
    chk("rm_keep_data", rsp_rdata, 32'hDEADBEEF);
    rsp_rdy = 1'b1;
    tick;
    tick;
    chk("rm_drain", rsp_vld, 1'b0);
    xact("rm_ld00", 1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
